// File: rtl/seq_divider.sv
// Sequential unsigned divider built on repeated subtraction.
// The dividend and then the divisor arrive on one shared bus in consecutive
// cycles. The divider then subtracts the divisor once per cycle until the
// remainder drops below it. The final quotient is the number of subtractions.
// A zero divisor skips the subtract loop: it returns an all-ones quotient,
// keeps the dividend as the remainder, and raises div_by_zero.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LDA,
      S_LDB,
      S_SUB,
      S_DONE
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] divisor;
   logic             rem_ge_div;

   // The subtract loop continues while the divisor still fits into the remainder.
   assign rem_ge_div = (remainder >= divisor);

   // Controller and datapath. busy, done and div_by_zero are registered, so
   // each one always matches the state that is being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         quotient    <= '0;
         remainder   <= '0;
         divisor     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_LDA;
                  busy  <= 1'b1;
               end
            end

            S_LDA: begin
               remainder   <= data_in;
               quotient    <= '0;
               div_by_zero <= 1'b0;
               state       <= S_LDB;
            end

            S_LDB: begin
               divisor <= data_in;
               if (data_in == '0) begin
                  // Remainder keeps the dividend that was captured in LDA.
                  quotient    <= '1;
                  div_by_zero <= 1'b1;
                  state       <= S_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end else begin
                  state <= S_SUB;
               end
            end

            S_SUB: begin
               if (rem_ge_div) begin
                  // The compare guards this subtract, so it cannot underflow.
                  // The quotient stays at or below the dividend, so it cannot overflow.
                  remainder <= remainder - divisor;
                  quotient  <= quotient + ONE;
               end else begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            S_DONE: begin
               if (start) begin
                  // Clear the flag on the way out. This keeps div_by_zero
                  // confined to DONE, even during the following LDA cycle.
                  state       <= S_LDA;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  div_by_zero <= 1'b0;
               end
            end

            default: begin
               state       <= S_IDLE;
               busy        <= 1'b0;
               done        <= 1'b0;
               div_by_zero <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: a 16-bit instance for the directed vectors
// and a WIDTH=8 instance for the randomized operand sweep.
module tb_seq_divider;

   localparam int BUDGET = 400;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start16 = 1'b0;
   logic [15:0] din16 = '0;
   logic [15:0] q16, r16;
   logic        busy16, done16, dbz16;
   logic        start8 = 1'b0;
   logic [7:0]  din8 = '0;
   logic [7:0]  q8, r8;
   logic        busy8, done8, dbz8;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .data_in(din16),
      .quotient(q16), .remainder(r16), .busy(busy16), .done(done16),
      .div_by_zero(dbz16)
   );

   seq_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .data_in(din8),
      .quotient(q8), .remainder(r8), .busy(busy8), .done(done8),
      .div_by_zero(dbz8)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] get_q(input bit w8);
      return w8 ? {8'h00, q8} : q16;
   endfunction
   function automatic logic [15:0] get_r(input bit w8);
      return w8 ? {8'h00, r8} : r16;
   endfunction
   function automatic logic get_busy(input bit w8);
      return w8 ? busy8 : busy16;
   endfunction
   function automatic logic get_done(input bit w8);
      return w8 ? done8 : done16;
   endfunction
   function automatic logic get_dbz(input bit w8);
      return w8 ? dbz8 : dbz16;
   endfunction

   task automatic set_in(input bit w8, input logic s, input logic [15:0] d);
      if (w8) begin
         start8 = s;
         din8   = d[7:0];
      end else begin
         start16 = s;
         din16   = d;
      end
   endtask

   // Drive start (sampled at E0), the dividend (captured at E1) and the divisor (captured at E2).
   task automatic launch(input bit w8, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk); set_in(w8, 1'b1, 16'h0000);
      @(posedge clk);
      @(negedge clk); set_in(w8, 1'b0, a);
      @(posedge clk);
      @(negedge clk); set_in(w8, 1'b0, b);
      @(posedge clk);
   endtask

   // Called right after E2. Returns the edge index at which done was seen.
   task automatic wait_done(input bit w8, output int lat, output bit hs_ok);
      hs_ok = 1'b1;
      lat = 2;
      #1;
      while (!get_done(w8) && lat < BUDGET) begin
         if (!get_busy(w8)) hs_ok = 1'b0;
         @(posedge clk);
         lat++;
         #1;
      end
      if (!get_done(w8)) begin
         errors++;
         $display("FAIL timeout: done not seen within %0d edges", BUDGET);
      end
      if (get_busy(w8)) hs_ok = 1'b0;
   endtask

   task automatic run_op(input bit w8, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dbz, output int lat, output bit hs_ok);
      launch(w8, a, b);
      wait_done(w8, lat, hs_ok);
      q   = get_q(w8);
      r   = get_r(w8);
      dbz = get_dbz(w8);
   endtask

   // busy and done are never high together, and div_by_zero never appears without done.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ((busy16 && done16) || (dbz16 && !done16) || (busy8 && done8) || (dbz8 && !done8)) begin
            errors++;
            $display("FAIL invariant: b16=%0d d16=%0d z16=%0d b8=%0d d8=%0d z8=%0d",
                     busy16, done16, dbz16, busy8, done8, dbz8);
         end
      end
   end

   initial begin
      logic [15:0] q, r;
      logic        dbz;
      int          lat;
      bit          hs;
      int          a, b;

      vecs[0] = '{a:16'd100,   b:16'd7,     q:16'd14,    r:16'd2,   dbz:1'b0, lat:17};
      vecs[1] = '{a:16'd5,     b:16'd9,     q:16'd0,     r:16'd5,   dbz:1'b0, lat:3};
      vecs[2] = '{a:16'd0,     b:16'd3,     q:16'd0,     r:16'd0,   dbz:1'b0, lat:3};
      vecs[3] = '{a:16'd42,    b:16'd0,     q:16'hFFFF,  r:16'd42,  dbz:1'b1, lat:2};
      vecs[4] = '{a:16'd8,     b:16'd2,     q:16'd4,     r:16'd0,   dbz:1'b0, lat:7};
      vecs[5] = '{a:16'd65535, b:16'd65535, q:16'd1,     r:16'd0,   dbz:1'b0, lat:4};
      vecs[6] = '{a:16'd1,     b:16'd1,     q:16'd1,     r:16'd0,   dbz:1'b0, lat:4};
      vecs[7] = '{a:16'd250,   b:16'd1,     q:16'd250,   r:16'd0,   dbz:1'b0, lat:253};
      vecs[8] = '{a:16'd1000,  b:16'd10,    q:16'd100,   r:16'd0,   dbz:1'b0, lat:103};

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_q",    32'(q16), 32'd0);
      chk("rst_r",    32'(r16), 32'd0);
      chk("rst_busy", 32'(busy16), 32'd0);
      chk("rst_done", 32'(done16), 32'd0);
      chk("rst_dbz",  32'(dbz16), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("idle_busy", 32'(busy16), 32'd0);

      // Table-driven directed vectors, run back to back
      for (int i = 0; i < 9; i++) begin
         run_op(1'b0, vecs[i].a, vecs[i].b, q, r, dbz, lat, hs);
         chk($sformatf("v%0d_q", i),   32'(q),   32'(vecs[i].q));
         chk($sformatf("v%0d_r", i),   32'(r),   32'(vecs[i].r));
         chk($sformatf("v%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_busy", i), 32'(hs), 32'd1);
      end

      // Results hold in DONE while start stays low
      repeat (3) @(posedge clk);
      #1;
      chk("hold_done", 32'(done16), 32'd1);
      chk("hold_q",    32'(q16), 32'd100);

      // Asynchronous reset in the middle of SUB
      launch(1'b0, 16'd1000, 16'd10);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_q",    32'(q16), 32'd0);
      chk("mid_rst_r",    32'(r16), 32'd0);
      chk("mid_rst_busy", 32'(busy16), 32'd0);
      chk("mid_rst_done", 32'(done16), 32'd0);
      chk("mid_rst_dbz",  32'(dbz16), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_done", 32'(done16), 32'd0);
      chk("post_rst_busy", 32'(busy16), 32'd0);
      run_op(1'b0, 16'd1000, 16'd10, q, r, dbz, lat, hs);
      chk("after_rst_q",   32'(q), 32'd100);
      chk("after_rst_r",   32'(r), 32'd0);
      chk("after_rst_lat", 32'(lat), 32'd103);

      // start held high: 20/6 then 9/3, with start toggled during SUB
      @(negedge clk); start16 = 1'b1; din16 = 16'd0;
      @(posedge clk);                          // E0
      @(negedge clk); din16 = 16'd20;
      @(posedge clk);                          // E1
      @(negedge clk); din16 = 16'd6;
      @(posedge clk);                          // E2
      @(negedge clk); start16 = 1'b0;
      @(posedge clk);                          // E3
      @(negedge clk); start16 = 1'b1;
      repeat (2) @(posedge clk);               // E5
      #1 chk("b2b_e5_done", 32'(done16), 32'd0);
      @(posedge clk);                          // E6
      #1;
      chk("b2b_1_done", 32'(done16), 32'd1);
      chk("b2b_1_q",    32'(q16), 32'd3);
      chk("b2b_1_r",    32'(r16), 32'd2);
      @(negedge clk); din16 = 16'd9;
      @(posedge clk);                          // E7
      #1;
      chk("b2b_e7_done", 32'(done16), 32'd0);
      chk("b2b_e7_busy", 32'(busy16), 32'd1);
      @(posedge clk);                          // E8
      @(negedge clk); din16 = 16'd3;
      @(posedge clk);                          // E9
      @(negedge clk); start16 = 1'b0;
      @(posedge clk);                          // E10
      @(negedge clk); start16 = 1'b1;
      repeat (2) @(posedge clk);               // E12
      #1 chk("b2b_e12_done", 32'(done16), 32'd0);
      @(posedge clk);                          // E13
      #1;
      chk("b2b_2_done", 32'(done16), 32'd1);
      chk("b2b_2_q",    32'(q16), 32'd3);
      chk("b2b_2_r",    32'(r16), 32'd0);
      @(negedge clk); start16 = 1'b0;
      @(posedge clk);
      #1 chk("b2b_hold_done", 32'(done16), 32'd1);

      // Random sweep on the 8-bit divider against plain integer division
      for (int i = 0; i < 500; i++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(1, 255));
         run_op(1'b1, 16'(a), 16'(b), q, r, dbz, lat, hs);
         chk($sformatf("rnd%0d_q(%0d/%0d)", i, a, b),   32'(q),   32'(a / b));
         chk($sformatf("rnd%0d_r(%0d/%0d)", i, a, b),   32'(r),   32'(a % b));
         chk($sformatf("rnd%0d_lat(%0d/%0d)", i, a, b), 32'(lat), 32'(3 + a / b));
         chk($sformatf("rnd%0d_dbz", i), 32'(dbz), 32'd0);
      end

      // Divide by zero on the 8-bit instance returns an all-ones quotient
      run_op(1'b1, 16'd77, 16'd0, q, r, dbz, lat, hs);
      chk("rnd_dz_q",   32'(q), 32'd255);
      chk("rnd_dz_r",   32'(r), 32'd77);
      chk("rnd_dz_dbz", 32'(dbz), 32'd1);
      chk("rnd_dz_lat", 32'(lat), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned divider using repeated subtraction; the inverse of the team's repeated-addition multiplier.
- Controller FSM and datapath (dividend/remainder register, divisor register, quotient counter, comparator) live in one block.
- Operands arrive one after the other on a shared data bus.
- Used wherever a slow, area-cheap divide with a start/done handshake is enough.

Parameters:
- WIDTH, 16, bit width of the operands, quotient and remainder.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level request; sampled only in IDLE and DONE.
- data_in  input  WIDTH  shared operand bus: dividend in the LDA cycle, divisor in the LDB cycle.
- quotient  output  WIDTH  result quotient; valid while done=1.
- remainder  output  WIDTH  result remainder; valid while done=1.
- busy  output  1  high in LDA, LDB and SUB.
- done  output  1  high only in DONE.
- div_by_zero  output  1  high in DONE when the captured divisor was 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - quotient, remainder, internal divisor register = 0.
  - busy=0, done=0, div_by_zero=0.
  - Applies immediately, including mid-operation; no partial result survives.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- FSM states:
  - IDLE: if start=1, go to LDA. Otherwise stay.
  - LDA: remainder<=data_in, quotient<=0, div_by_zero<=0; go to LDB.
  - LDB: divisor<=data_in.
    - If data_in==0: quotient<=all ones, remainder keeps the dividend, div_by_zero<=1; go to DONE.
    - Otherwise go to SUB.
  - SUB, evaluated each cycle:
    - If remainder>=divisor: remainder<=remainder-divisor, quotient<=quotient+1; stay in SUB.
    - Else: go to DONE with no register change.
  - DONE: results hold.
    - If start=1, go to LDA. A new operation begins and the results are overwritten in LDA/LDB.
    - Otherwise stay.
- Latency:
  - Let E0 be the edge where start is sampled high.
  - Dividend is captured at E1 and divisor at E2.
  - done rises after edge E(3+Q), where Q is the final quotient.
  - Divide by zero: done rises after E2.
- Arithmetic:
  - All values are unsigned WIDTH bits.
  - Subtraction never underflows because it is guarded by the compare.
  - Quotient cannot overflow because Q <= dividend.
- Boundary conditions:
  - Dividend 0 gives Q=0, R=0, with one SUB cycle.
  - Dividend < divisor gives Q=0, R=dividend.
  - Divisor 1 gives Q=dividend, which is the worst-case latency of 3+2^WIDTH-1 cycles.
- start is ignored in LDA, LDB and SUB. Toggling start mid-operation has no effect.
- If start is held high continuously, back-to-back operations run. DONE lasts exactly one cycle between them.
- Invariants:
  - busy and done are never high together.
  - div_by_zero=1 only when done=1 (it is cleared in LDA).

Test Plan:
- Reset, then start=1 at E0, data_in=100 at E1 and 7 at E2 -> done=1 after E17; quotient=14, remainder=2, div_by_zero=0; busy high E0..E17 exclusive of DONE.
- Dividend 5, divisor 9 -> done after E3; quotient=0, remainder=5. Dividend 0, divisor 3 -> quotient=0, remainder=0, done after E3.
- Dividend 42, divisor 0 -> done after E2; div_by_zero=1, quotient=16'hFFFF, remainder=42. The next operation (8/2) clears div_by_zero and gives quotient=4, remainder=0.
- Dividend 1000, divisor 10, with rst_n pulsed low asynchronously during SUB (mid-clock) -> all outputs 0 immediately, state IDLE, no done. A following 1000/10 gives quotient=100, remainder=0.
- start held high throughout with operands 20/6 then 9/3 -> first DONE lasts one cycle with Q=3, R=2, then Q=3, R=0; start toggled during SUB does not perturb results.
- Random sweep of 500 WIDTH=8 operand pairs -> quotient*divisor+remainder==dividend, remainder<divisor, and latency==3+quotient for every pair.
